gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 103 ++++++++++
 tb/tb_gshare_predictor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Gshare branch direction predictor: a table of 2^IDX_W saturating counters
//   indexed by (PC index XOR global history). Lookups return a registered
//   prediction one cycle later together with the history snapshot used, and
//   speculatively shift the predicted direction into the global history.
//   Resolved branches train their counter; a mispredict restores the history
//   from the returned snapshot plus the real outcome.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   pred_valid      lookup request this cycle
//   pred_idx        PC-derived lookup index
//   out_valid       registered prediction valid
//   out_taken       registered predicted direction (counter MSB)
//   out_ghr         history snapshot used by the lookup
//   upd_valid       training request for a resolved branch
//   upd_idx         PC-derived index of the resolved branch
//   upd_ghr         history snapshot previously returned on out_ghr
//   upd_taken       resolved direction
//   upd_mispredict  resolved direction differed from the prediction

module gshare_predictor #(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2,
    parameter int GHR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             out_valid,
    output logic             out_taken,
    output logic [GHR_W-1:0] out_ghr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispredict
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = '0;
    localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};

    logic [CTR_W-1:0] ctr_table [ENTRIES];
    logic [GHR_W-1:0] ghr;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] train_idx;
    logic             pred_dir;
    logic [CTR_W-1:0] train_cur;
    logic [CTR_W-1:0] train_next;
    logic             recover;
    logic [GHR_W-1:0] ghr_spec;
    logic [GHR_W-1:0] ghr_recovered;

    always_comb begin
        lookup_idx    = pred_idx ^ IDX_W'(ghr);
        train_idx     = upd_idx ^ IDX_W'(upd_ghr);
        // Table read happens before the edge, so a same-cycle update to the
        // same entry is not visible to the lookup.
        pred_dir      = ctr_table[lookup_idx][CTR_W-1];
        train_cur     = ctr_table[train_idx];
        recover       = upd_valid & upd_mispredict;
        // Concatenate-then-truncate keeps the shift legal for GHR_W = 1.
        ghr_spec      = GHR_W'({ghr, pred_dir});
        ghr_recovered = GHR_W'({upd_ghr, upd_taken});

        train_next = train_cur;
        if (upd_taken) begin
            if (train_cur != CTR_MAX) train_next = train_cur + 1'b1;
        end else begin
            if (train_cur != CTR_ZERO) train_next = train_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_WEAK;
            ghr       <= '0;
            out_valid <= 1'b0;
            out_taken <= 1'b0;
            out_ghr   <= '0;
        end else begin
            if (upd_valid) ctr_table[train_idx] <= train_next;

            // Recovery outranks a coincident lookup: that lookup is dropped.
            if (recover) begin
                ghr       <= ghr_recovered;
                out_valid <= 1'b0;
            end else if (pred_valid) begin
                ghr       <= ghr_spec;
                out_valid <= 1'b1;
                out_taken <= pred_dir;
                out_ghr   <= ghr;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

    logic       clk = 0;
    logic       rst = 0;
    logic       pred_valid = 0;
    logic [3:0] pred_idx = 0;
    logic       out_valid;
    logic       out_taken;
    logic [3:0] out_ghr;
    logic       upd_valid = 0;
    logic [3:0] upd_idx = 0;
    logic [3:0] upd_ghr = 0;
    logic       upd_taken = 0;
    logic       upd_mispredict = 0;

    gshare_predictor #(.IDX_W(4), .CTR_W(2), .GHR_W(4)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_idx(pred_idx),
        .out_valid(out_valid), .out_taken(out_taken), .out_ghr(out_ghr),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: counters as integers 0..3, history as integer 0..15.
    int m_ctr [16];
    int m_ghr;
    int m_ov, m_ot, m_og;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ctr[i] = 2;
        m_ghr = 0; m_ov = 0; m_ot = 0; m_og = 0;
    endtask

    task automatic model_step();
        int li, ui, pred;
        if (rst) begin
            model_reset();
            return;
        end
        li = int'(pred_idx) ^ m_ghr;
        ui = int'(upd_idx) ^ int'(upd_ghr);
        pred = (m_ctr[li] >= 2) ? 1 : 0;
        if (upd_valid) begin
            if (upd_taken) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            else           m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
        if (upd_valid && upd_mispredict) begin
            m_ghr = (int'(upd_ghr) * 2 + int'(upd_taken)) % 16;
            m_ov = 0;
        end else if (pred_valid) begin
            m_ot = pred;
            m_og = m_ghr;
            m_ghr = (m_ghr * 2 + pred) % 16;
            m_ov = 1;
        end else begin
            m_ov = 0;
        end
    endtask

    task automatic compare_outputs();
        check("out_valid", int'(out_valid), m_ov);
        check("out_taken", int'(out_taken), m_ot);
        check("out_ghr",   int'(out_ghr),   m_og);
    endtask

    // Inputs are already driven; advance one edge, step model, compare.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
        #1;
    endtask

    task automatic drive(input logic pv, input logic [3:0] pi, input logic uv,
                         input logic [3:0] ui, input logic [3:0] ug,
                         input logic ut, input logic um);
        pred_valid = pv; pred_idx = pi;
        upd_valid = uv; upd_idx = ui; upd_ghr = ug;
        upd_taken = ut; upd_mispredict = um;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 1),
              4'($urandom), 4'($urandom), $urandom_range(0, 1),
              ($urandom_range(0, 3) == 0));
    endtask

    // Reset raised and dropped between edges while traffic continues.
    task automatic async_reset_pulse();
        #1 rst = 1;
        model_reset();
        #1;
        compare_outputs();
        check("rst_out_valid_now", int'(out_valid), 0);
        for (int k = 0; k < 2; k++) begin
            drive_random();
            cycle();
        end
        #1 rst = 0;
        idle();
        cycle();
        check("no_stale_valid", int'(out_valid), 0);
    endtask

    initial begin
        logic [3:0] exp_og [6];
        exp_og = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF};
        model_reset();

        // Power-on reset.
        rst = 1;
        idle();
        @(posedge clk); #1;
        compare_outputs();
        check("reset_valid", int'(out_valid), 0);
        #1 rst = 0;
        #1;

        // Lookups 0..15 after reset: all taken, history fills with ones.
        for (int i = 0; i < 16; i++) begin
            drive(1, 4'(i), 0, 0, 0, 0, 0);
            cycle();
            check("init_taken", int'(out_taken), 1);
            check("init_valid", int'(out_valid), 1);
            if (i < 6) check("init_ghr_seq", int'(out_ghr), int'(exp_og[i]));
        end

        // Five not-taken updates to entry 3 with ghr 0: 2,1,0,0,0.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 4'd3, 4'd0, 0, 0);
            cycle();
            check("dec_sat_model", m_ctr[3], (i == 0) ? 1 : 0);
        end
        // Recovery to ghr 0 (trains entry 5), then lookup idx 3.
        drive(0, 0, 1, 4'd5, 4'd0, 0, 1);
        cycle();
        drive(1, 4'd3, 0, 0, 0, 0, 0);
        cycle();
        check("idx3_not_taken", int'(out_taken), 0);
        check("idx3_ghr0", int'(out_ghr), 0);

        // Four taken updates to entry 9 (at 2): 3,3,3,3, no wrap.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 4'd9, 4'd0, 1, 0);
            cycle();
            check("inc_sat_model", m_ctr[9], 3);
        end

        // Force ghr = 1011, then recovery coinciding with a lookup.
        drive(0, 0, 1, 4'b0101, 4'b0101, 1, 1);
        cycle();
        drive(1, 4'd2, 1, 4'd0, 4'b0100, 1, 1);
        cycle();
        check("recover_drops_lookup", int'(out_valid), 0);
        drive(1, 4'd0, 0, 0, 0, 0, 0);
        cycle();
        check("recovered_ghr", int'(out_ghr), 4'b1001);

        // Same-cycle lookup and update to a fresh entry: pre-update value.
        async_reset_pulse();
        drive(1, 4'd6, 1, 4'd6, 4'd0, 0, 0);
        cycle();
        check("bypass_pre_update", int'(out_taken), 1);
        check("entry6_model", m_ctr[6], 1);
        drive(1, 4'd7, 0, 0, 0, 0, 0);   // 7 ^ ghr(1) = 6
        cycle();
        check("entry6_after", int'(out_taken), 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
            drive_random();
            cycle();
        end

        // After a reset every index predicts taken.
        async_reset_pulse();
        for (int i = 0; i < 16; i++) begin
            drive(1, 4'(i), 0, 0, 0, 0, 0);
            cycle();
            check("post_reset_taken", int'(out_taken), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
